add_roundkey_seq: RTL

ADD_ROUNDKEY_SEQ -- requirements
Module: add_roundkey_seq

---
 rtl/add_roundkey_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/add_roundkey_seq.sv
// add_roundkey_seq: stores a full expanded AES key schedule word by word and
// XORs a caller-supplied state with one round key per step. It walks the keys
// upward for encryption and downward for decryption.
module add_roundkey_seq #(
  parameter int NR = 10,
  parameter int W  = 128
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         key_wr_en,
  input  logic [31:0]  key_word,
  output logic         key_loaded,
  input  logic         start,
  input  logic         decrypt,
  input  logic         step,
  input  logic [W-1:0] state_in,
  output logic [W-1:0] state_out,
  output logic         out_valid,
  output logic [3:0]   round,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned WPK    = W / 32;
  localparam int unsigned NWORDS = (NR + 1) * WPK;
  localparam int unsigned AW     = $clog2(NWORDS);

  typedef enum logic [1:0] {EMPTY, LOADING, READY, BUSY} state_t;

  state_t         state, state_next;
  logic [31:0]    mem [NWORDS];
  logic [AW-1:0]  wptr, waddr;
  logic [3:0]     counter;
  logic           dec_r;
  logic           mem_we, wr_last, start_ok, step_ok, step_last, bad_req;
  logic [W-1:0]   rkey;

  // Request decode: which requests are legal in the current state. A write in
  // READY restarts the load at address 0 unless start claims the same cycle.
  always_comb begin
    start_ok  = start && (state == READY);
    step_ok   = step && (state == BUSY);
    mem_we    = key_wr_en && ((state == EMPTY) || (state == LOADING) ||
                              ((state == READY) && !start));
    waddr     = (state == READY) ? '0 : wptr;
    wr_last   = mem_we && (state != READY) && (wptr == AW'(NWORDS - 1));
    step_last = dec_r ? (counter == '0) : (counter == 4'(NR));
    bad_req   = (key_wr_en && !mem_we) || (start && !start_ok) || (step && !step_ok);
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= EMPTY;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY, LOADING: if (mem_we) state_next = wr_last ? READY : LOADING;
      READY: begin
        if (start_ok)    state_next = BUSY;
        else if (mem_we) state_next = LOADING;
      end
      BUSY:    if (step_ok && step_last) state_next = READY;
      default: state_next = EMPTY;
    endcase
  end

  // Moore outputs derived from the state register.
  always_comb begin
    busy       = (state == BUSY);
    key_loaded = (state == READY) || (state == BUSY);
  end

  // Key store. It has no reset: the FSM returns to EMPTY on reset, so the old
  // contents stay unreachable until a complete reload.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[waddr] <= key_word;
  end

  // Round-key read: word j of key k sits at k*WPK+j, with the MS word first.
  always_comb begin
    rkey = '0;
    for (int unsigned j = 0; j < WPK; j++)
      rkey[W-1-32*j -: 32] = mem[AW'(32'(counter) * WPK + j)];
  end

  // Write pointer, round counter, XOR datapath and pulse outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wptr      <= '0;
      counter   <= '0;
      dec_r     <= 1'b0;
      state_out <= '0;
      round     <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= bad_req;
      if (mem_we) wptr <= wr_last ? '0 : waddr + AW'(1);
      if (start_ok) begin
        dec_r   <= decrypt;
        counter <= decrypt ? 4'(NR) : '0;
      end
      if (step_ok) begin
        state_out <= state_in ^ rkey;
        round     <= counter;
        out_valid <= 1'b1;
        if (step_last) done    <= 1'b1;
        else if (dec_r) counter <= counter - 4'd1;
        else            counter <= counter + 4'd1;
      end
    end
  end

endmodule
